// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch front-end for the single-cycle CPU core. Issues one word read at a
// time to a variable-latency instruction memory (req/ack handshake), buffers
// returned words with their PCs in a DEPTH-entry prefetch queue, and presents
// the head of the queue to the core over valid/ready. A redirect from the
// core flushes the queue and abandons (drains and discards) any in-flight read.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   mem_req      out  read request to instruction memory
//   mem_addr     out  word address of the request ([1:0] always 0)
//   mem_ack      in   one-cycle pulse, mem_rdata valid, request complete
//   mem_rdata    in   instruction word returned
//   instr        out  head-of-queue instruction
//   instr_pc     out  PC of instr
//   instr_valid  out  queue non-empty
//   instr_ready  in   core consumes head this cycle
//   redirect     in   flush and restart fetch
//   redirect_pc  in   new fetch PC ([1:0] treated as 0)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   q_pc_q    [DEPTH];

  logic          pop_s;
  logic          push_s;
  logic [CW-1:0] count_after_pop_s;
  logic [31:0]   redirect_pc_s;
  logic [31:0]   fetch_pc_inc_s;

  assign instr_valid       = (count_q != {CW{1'b0}});
  assign pop_s             = instr_valid & instr_ready;
  // Only a read issued for the current fetch stream may be queued.
  assign push_s            = (state_q == REQ) & mem_ack & ~redirect;
  assign count_after_pop_s = count_q - CW'(pop_s);
  assign redirect_pc_s     = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_pc_inc_s    = fetch_pc_q + 32'd4;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign instr    = q_instr_q[rd_ptr_q];
  assign instr_pc = q_pc_q[rd_ptr_q];

  // Next-state logic: queue bookkeeping and the fetch request FSM.
  // In REQ, fetch_pc_q is the address of the outstanding read; in DROP it is
  // the redirect target to fetch once the abandoned read completes.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;

    if (redirect) begin
      count_d    = {CW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      fetch_pc_d = redirect_pc_s;
    end else begin
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
      wr_ptr_d = wr_ptr_q + PW'(push_s);
    end

    case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc_s;
        end else if (count_after_pop_s < DEPTH_C) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redirect && mem_ack) begin
          // Returned word belongs to the old stream; restart immediately.
          state_d    = REQ;
          mem_addr_d = redirect_pc_s;
        end else if (redirect) begin
          // Read still in flight: keep the handshake stable until it drains.
          state_d = DROP;
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_inc_s;
          if (count_d < DEPTH_C) begin
            state_d    = REQ;
            mem_addr_d = fetch_pc_inc_s;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end else begin
          state_d = REQ;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d    = REQ;
          mem_addr_d = redirect ? redirect_pc_s : fetch_pc_q;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      count_q    <= {CW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Prefetch queue storage; cleared on reset so instr/instr_pc read as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= 32'h0000_0000;
        q_pc_q[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      q_instr_q[wr_ptr_q] <= mem_rdata;
      q_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end else begin
      q_instr_q[wr_ptr_q] <= q_instr_q[wr_ptr_q];
      q_pc_q[wr_ptr_q]    <= q_pc_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int lat  = 0;
  int mcnt = 0;
  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  // Memory model: acks after `lat` idle cycles, returns addr + 0x1000.
  // Tolerates mem_req dropping (pending read forgotten).
  always @(negedge clk) begin
    if (mem_req) begin
      if (mcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr + 32'h1000;
        mcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        mcnt    = mcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget);
    int n;
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === a) && n < budget) begin
      tick();
      n++;
    end
    check("wait_addr", {31'b0, (mem_req === 1'b1 && mem_addr === a)}, 32'd1);
  endtask

  initial begin
    int n;
    // Reset state
    #2 rst_n = 1'b0;
    tick();
    check("rst_req",   {31'b0, mem_req}, 32'd0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    instr_pc, 32'h0);

    // Zero-wait streaming, one instruction per cycle
    lat = 0;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    check("s_req0",   {31'b0, mem_req}, 32'd1);
    check("s_addr0",  mem_addr, 32'h0);
    check("s_valid0", {31'b0, instr_valid}, 32'd0);
    tick();
    check("s_valid1", {31'b0, instr_valid}, 32'd1);
    check("s_instr1", instr, 32'h1000);
    check("s_pc1",    instr_pc, 32'h0);
    check("s_addr1",  mem_addr, 32'h4);
    tick();
    check("s_instr2", instr, 32'h1004);
    check("s_addr2",  mem_addr, 32'h8);
    tick();
    check("s_instr3", instr, 32'h1008);
    check("s_addr3",  mem_addr, 32'hC);

    // Queue fills with no consumer, then refetch at 0x10 on first pop
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("full_req",   {31'b0, mem_req}, 32'd0);
    check("full_valid", {31'b0, instr_valid}, 32'd1);
    check("full_instr", instr, 32'h1000);
    tick();
    check("full_req2",  {31'b0, mem_req}, 32'd0);
    instr_ready = 1'b1;
    tick();
    check("refill_req",   {31'b0, mem_req}, 32'd1);
    check("refill_addr",  mem_addr, 32'h10);
    check("refill_instr", instr, 32'h1004);
    check("refill_pc",    instr_pc, 32'h4);

    // 3-cycle latency, redirect mid-request drops the returning word
    lat = 3;
    do_reset();
    wait_addr(32'h8, 40);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("drop_req",   {31'b0, mem_req}, 32'd1);
    check("drop_addr",  mem_addr, 32'h8);
    check("drop_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("drop_addr2", mem_addr, 32'h8);
    tick();
    check("drop_new_addr", mem_addr, 32'h200);
    check("drop_valid2",   {31'b0, instr_valid}, 32'd0);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("drop_lat",   n, 32'd4);
    check("drop_instr", instr, 32'h1200);
    check("drop_pc",    instr_pc, 32'h200);

    // Redirect coincident with ack of C, unaligned target 0x43
    lat = 0;
    do_reset();
    wait_addr(32'hC, 10);
    redirect = 1'b1;
    redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    check("rack_addr",  mem_addr, 32'h40);
    check("rack_req",   {31'b0, mem_req}, 32'd1);
    check("rack_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("rack_valid2", {31'b0, instr_valid}, 32'd1);
    check("rack_pc",     instr_pc, 32'h40);
    check("rack_instr",  instr, 32'h1040);

    // Full queue, simultaneous pop and redirect to 0x80
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("f_req",   {31'b0, mem_req}, 32'd0);
    check("f_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    instr_ready = 1'b0;
    check("fr_valid", {31'b0, instr_valid}, 32'd0);
    check("fr_req",   {31'b0, mem_req}, 32'd1);
    check("fr_addr",  mem_addr, 32'h80);
    tick();
    check("fr_pc",    instr_pc, 32'h80);
    check("fr_instr", instr, 32'h1080);

    // PC wrap at top of address space
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", mem_addr, 32'h0);
    check("wrap_pc",    instr_pc, 32'hFFFF_FFFC);
    check("wrap_instr", instr, 32'h0000_0FFC);

    // Asynchronous reset mid-REQ clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    check("arst_req",   {31'b0, mem_req}, 32'd0);
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_instr", instr, 32'h0);
    check("arst_pc",    instr_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_req2",  {31'b0, mem_req}, 32'd1);
    check("arst_addr2", mem_addr, 32'h0);
    tick();
    check("arst_instr2", instr, 32'h1000);
    check("arst_pc2",    instr_pc, 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
